subtrator_serial_8bits: RTL and testbench

- Bit-serial, multi-cycle subtractor for the 8-bit ULA datapath: computes S = A − B one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse operation of the combinational ripple-carry adder. It is built for the area-constrained ULA variant and drives the ULA result mux and status flags.
- It uses a start/busy/done handshake and holds its outputs stable between operations.

---
 rtl/subtrator_serial_8bits.sv | 161 ++++++++++++++++
 tb/tb_subtrator_serial_8bits.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial_8bits.sv
// rtl/subtrator_serial_8bits.sv - bit-serial A-B subtractor, LSB first, with start/busy/done handshake

// Single-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module subtrator_full_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module subtrator_serial_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_sh_q, r_sh_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sgn_q, sgn_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               bout_q, bout_d;
  logic               z_q, z_d;
  logic               v_q, v_d;

  logic               bit_d;
  logic               bit_borrow;
  logic               last_bit;
  logic [WIDTH-1:0]   s_fin;

  subtrator_full_sub_cell u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bit_d),
    .bout_o (bit_borrow)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign s_fin    = {bit_d, r_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Result and flags only move on the RUN->DONE edge, so they hold across IDLE and the next RUN.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    s_d      = s_q;
    bout_d   = bout_q;
    z_d      = z_q;
    v_d      = v_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          sgn_d    = {A[WIDTH-1], B[WIDTH-1]};
        end
      end
      ST_RUN: begin
        borrow_d = bit_borrow;
        r_sh_d   = s_fin;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          s_d    = s_fin;
          bout_d = bit_borrow;
          z_d    = (s_fin == '0);
          v_d    = (sgn_q[1] != sgn_q[0]) && (s_fin[WIDTH-1] != sgn_q[1]);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      sgn_q    <= '0;
      s_q      <= '0;
      bout_q   <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      s_q      <= s_d;
      bout_q   <= bout_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

  assign S    = s_q;
  assign Bout = bout_q;
  assign Z    = z_q;
  assign V    = v_q;

endmodule

// File: tb/tb_subtrator_serial_8bits.sv
// tb/tb_subtrator_serial_8bits.sv - directed-vector bench for subtrator_serial_8bits

module tb_subtrator_serial_8bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] S;
  logic       Bout;
  logic       Z;
  logic       V;

  int total = 0;
  int bad   = 0;
  logic [7:0] last_s;

  subtrator_serial_8bits #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Bout  (Bout),
    .Z     (Z),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check handshake timing and the result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic eb, input logic ez, input logic ev);
    int n;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_hold_run"}, S, last_s);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_S"}, S, es);
    check({tag, "_Bout"}, Bout, eb);
    check({tag, "_Z"}, Z, ez);
    check({tag, "_V"}, V, ev);
    check({tag, "_busy_done"}, busy, 0);
    tick();
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold_idle"}, S, es);
    last_s = es;
  endtask

  initial begin
    int n;
    int unstable;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    last_s = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 0);
    check("rst_flags", {Bout, Z, V}, 3'b000);
    tick();

    run_op("basic",  8'h50, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("under",  8'h20, 8'h50, 8'hD0, 1'b1, 1'b0, 1'b0);
    run_op("ovf1",   8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op("ovf2",   8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
    run_op("zero1",  8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("zero2",  8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // start pulsed mid-operation must be ignored
    A = 8'h10; B = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("ign_latency", n, 8);
    check("ign_S", S, 8'h0F);
    check("ign_Bout", Bout, 0);
    tick();
    tick();
    check("ign_no_restart", busy, 0);
    last_s = 8'h0F;

    // reset mid-operation aborts with no done pulse, then IDLE accepts at once
    A = 8'h10; B = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_S", S, 0);
    last_s = 8'h00;
    run_op("post_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0);

    // rst and start together: rst wins
    A = 8'h44; B = 8'h11; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_S", S, 0);
    tick();
    check("rst_start_idle", busy, 0);
    last_s = 8'h00;

    // start held high: one result every WIDTH+2 edges, outputs stable while A/B toggle in RUN
    A = 8'h05; B = 8'h03; start = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_first_latency", n, 9);
    check("b2b_first_S", S, 8'h02);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      unstable = 0;
      do begin
        tick();
        n++;
        if (S !== 8'h02) unstable++;
        if (busy) begin
          A = 8'($urandom);
          B = 8'($urandom);
        end else begin
          A = 8'h05;
          B = 8'h03;
        end
      end while (!done && n < 30);
      check($sformatf("b2b_interval%0d", p), n, 10);
      check($sformatf("b2b_S%0d", p), S, 8'h02);
      check($sformatf("b2b_stable%0d", p), unstable, 0);
    end
    start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
